alu_share_ctl: RTL and testbench
================================

# alu_share_ctl

Two-requester scheduler that shares the single 16-bit integer/float ALU between two issuing agents, e.g. the two instruction streams of the pipeline. It arbitrates round-robin and registers and holds the winner's operands on the ALU inputs for the op's latency. It captures the ALU result and returns it to the winning requester with a one-cycle response pulse. Integer ops complete in one execute cycle. Float ops (invf, addf, mulf, f2i, i2f) are given FLOAT_LAT execute cycles so the normalization path settles.

## Interface
- FLOAT_LAT, default 3: execute cycles for float ops; legal range 1..15.
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  synchronous reset, active low.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  requester 0 granted this cycle.
- req0_op  in  4  opcode in ALU encoding.
- req0_x, req0_y  in  16 each  operands.
- req1_valid, req1_ready, req1_op, req1_x, req1_y: same as requester 0, for requester 1.
- alu_op  out  4  registered opcode to the ALU.
- alu_x, alu_y  out  16 each  registered operands to the ALU.
- alu_z  in  16  combinational ALU result.
- rsp0_valid  out  1  one-cycle response pulse to requester 0.
- rsp0_z  out  16  result for requester 0.
- rsp0_err  out  1  the op was illegal; valid with rsp0_valid.
- rsp1_valid, rsp1_z, rsp1_err: same as the requester 0 response, for requester 1.
- busy  out  1  state is not IDLE.

## Operation
- States are IDLE, EXEC and DONE. Registers:
  - state
  - cnt[3:0]
  - owner (1 bit)
  - rr (1 bit; the requester with priority on a tie)
  - op_r, x_r, y_r
  - z_r, err_r
- Op classes:
  - int: 0000 add, 0100 and, 0101 or, 0110 xor, 0111 any, 1000 dup, 1001 shr.
  - float: 0001 invf, 0010 addf, 0011 mulf, 1010 f2i, 1011 i2f.
  - illegal: 1100–1111 (ld/st/jzsz/li are not ALU ops).
- IDLE:
  - reqN_ready = valid-qualified grant. Only one requester is valid: it wins. Both are valid: requester rr wins.
  - req*_ready is 0 in every state other than IDLE.
  - On a handshake (valid & ready): latch op/x/y into op_r/x_r/y_r and record owner.
  - Int op: cnt ← 0, go to EXEC.
  - Float op: cnt ← FLOAT_LAT−1, go to EXEC.
  - Illegal op: z_r ← 0, err_r ← 1, go straight to DONE; the ALU inputs are not updated.
- EXEC:
  - alu_op/alu_x/alu_y = op_r/x_r/y_r, stable for the whole state.
  - cnt ≠ 0: decrement cnt.
  - cnt = 0: z_r ← alu_z, err_r ← 0, go to DONE.
- DONE:
  - rsp{owner}_valid = 1 for exactly this cycle; rsp{owner}_z = z_r; rsp{owner}_err = err_r.
  - The other requester's rsp outputs are 0.
  - rr ← ~owner; go to IDLE.
- Responses have no backpressure; requesters must accept them.
- The x/y operand order is passed through unchanged.
- All result bits come from alu_z; the block does no arithmetic.

## Timing
- Reset (reset_n = 0 at an edge):
  - state = IDLE, rr = 0, cnt = 0, owner = 0.
  - alu_op = 1000 (dup), alu_x = alu_y = 0, z_r = 0, err_r = 0.
  - All ready, rsp and busy outputs are 0.
- Handshake at cycle T:
  - Int op: EXEC at T+1; rsp valid at T+2; next grant possible at T+3.
  - Float op: EXEC during T+1..T+FLOAT_LAT; rsp valid at T+FLOAT_LAT+1.
  - Illegal op: rsp valid with err = 1 at T+1.
- Back-to-back issue rate is one op per (latency + 2) cycles.
- Both requesters valid continuously: grants alternate 0, 1, 0, 1…
- A request that drops valid before being granted is forgotten; nothing is queued.
- Inputs are sampled only at the handshake edge; later changes on req* have no effect.
- Reset during EXEC or DONE: the op is aborted, no rsp pulse is produced, and rr returns to 0.
- Outputs op_r/x_r/y_r hold their last values in IDLE/DONE; only a new handshake changes them.

## Test plan
- Reset: hold reset_n = 0 for 2 cycles with both requesters valid.
  - Required: all ready, rsp and busy are 0; alu_op = 1000; alu_x = alu_y = 0.
  - After release: req0_ready = 1 in the first cycle.
- Int op: req0 issues add with x = 0x0003, y = 0x0004 at T; ALU model returns x+y.
  - Required: alu_x = 0x0003 at T+1; rsp0_valid = 1 with rsp0_z = 0x0007 and rsp0_err = 0 at T+2 only.
- Float op, FLOAT_LAT = 3: req1 issues mulf with x = 0x3FC0, y = 0x4000; the ALU model is registered-stable.
  - Required: alu inputs constant during T+1..T+3.
  - rsp1_valid at T+4, with rsp1_z equal to the model output for those operands.
- Contention: both requesters valid with add from reset.
  - Required: grant order req0, req1, req0.
  - Each rsp goes only to its own requester; rsp on the other port stays 0.
- Illegal op: req0 issues op = 1101.
  - Required: rsp0_valid = 1, rsp0_err = 1, rsp0_z = 0x0000 at T+1; alu_op unchanged.
- Abort: reset_n = 0 at T+2 of a FLOAT_LAT = 3 op.
  - Required: no rsp pulse ever; state is IDLE.
  - The next grant goes to req0 even if req1 was the owner.

Source files
------------

// File: rtl/alu_share_ctl.sv
// alu_share_ctl
// Shares one 16-bit integer/float ALU between two requesters.
// Round-robin grant in IDLE; the winner's op/operands are registered onto the
// ALU inputs and held for the op's latency. The result is captured and returned
// to the winner with a one-cycle response pulse.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   req{0,1}_valid/op/x/y        request from each requester
//   req{0,1}_ready               valid-qualified grant, only in IDLE
//   alu_op, alu_x, alu_y         registered ALU inputs
//   alu_z                        combinational ALU result
//   rsp{0,1}_valid/z/err         one-cycle response to the owning requester
//   busy                         controller is not IDLE
module alu_share_ctl #(
    parameter int unsigned FLOAT_LAT = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [15:0] req0_x,
    input  logic [15:0] req0_y,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [15:0] req1_x,
    input  logic [15:0] req1_y,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    input  logic [15:0] alu_z,
    output logic        rsp0_valid,
    output logic [15:0] rsp0_z,
    output logic        rsp0_err,
    output logic        rsp1_valid,
    output logic [15:0] rsp1_z,
    output logic        rsp1_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // cnt counts remaining extra execute cycles, so a float op loads LAT-1.
    localparam logic [3:0] FLOAT_CNT = 4'(FLOAT_LAT - 32'd1);
    localparam logic [3:0] OP_DUP    = 4'b1000;

    // ld/st/jzsz/li occupy the top quarter of the opcode space.
    function automatic logic op_is_illegal(input logic [3:0] op);
        return (op[3:2] == 2'b11);
    endfunction

    function automatic logic op_is_float(input logic [3:0] op);
        logic f;
        case (op)
            4'b0001, 4'b0010, 4'b0011, 4'b1010, 4'b1011: f = 1'b1;
            default:                                     f = 1'b0;
        endcase
        return f;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        rr_q, rr_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [15:0] z_q, z_d;
    logic        err_q, err_d;

    logic        gnt0_s, gnt1_s;
    logic [3:0]  sel_op_s;
    logic [15:0] sel_x_s, sel_y_s;

    // Next-state logic, grant selection and ready outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        op_d       = op_q;
        x_d        = x_q;
        y_d        = y_q;
        z_d        = z_q;
        err_d      = err_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        // A lone valid requester wins; on a tie rr decides. Reset blocks grants.
        gnt0_s   = reset_n && req0_valid && (!req1_valid || !rr_q);
        gnt1_s   = reset_n && req1_valid && (!req0_valid ||  rr_q);
        sel_op_s = gnt1_s ? req1_op : req0_op;
        sel_x_s  = gnt1_s ? req1_x  : req0_x;
        sel_y_s  = gnt1_s ? req1_y  : req0_y;

        case (state_q)
            ST_IDLE: begin
                req0_ready = gnt0_s;
                req1_ready = gnt1_s;
                if (gnt0_s || gnt1_s) begin
                    owner_d = gnt1_s;
                    if (op_is_illegal(sel_op_s)) begin
                        // ALU inputs deliberately left untouched.
                        z_d     = 16'h0000;
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        op_d    = sel_op_s;
                        x_d     = sel_x_s;
                        y_d     = sel_y_s;
                        cnt_d   = op_is_float(sel_op_s) ? FLOAT_CNT : 4'd0;
                        state_d = ST_EXEC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    z_d     = alu_z;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                rr_d    = ~owner_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            op_q    <= OP_DUP;
            x_q     <= 16'h0000;
            y_q     <= 16'h0000;
            z_q     <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            err_q   <= err_d;
        end
    end

    assign alu_op = op_q;
    assign alu_x  = x_q;
    assign alu_y  = y_q;
    assign busy   = (state_q != ST_IDLE);

    // Responses are decoded straight from registered state; non-owner sees 0.
    assign rsp0_valid = (state_q == ST_DONE) && !owner_q;
    assign rsp1_valid = (state_q == ST_DONE) &&  owner_q;
    assign rsp0_z     = rsp0_valid ? z_q : 16'h0000;
    assign rsp1_z     = rsp1_valid ? z_q : 16'h0000;
    assign rsp0_err   = rsp0_valid ? err_q : 1'b0;
    assign rsp1_err   = rsp1_valid ? err_q : 1'b0;

endmodule

// File: tb/tb_alu_share_ctl.sv
// Testbench for alu_share_ctl: directed steps followed by randomized traffic,
// every cycle compared against a transaction-level model of the scheduler.
module tb_alu_share_ctl;

    localparam int FL = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [15:0] req0_x, req0_y, req1_x, req1_y;
    logic [3:0]  alu_op;
    logic [15:0] alu_x, alu_y, alu_z;
    logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
    logic [15:0] rsp0_z, rsp1_z;
    logic        busy;

    always #5 clk = ~clk;

    alu_share_ctl #(.FLOAT_LAT(FL)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_x(req1_x), .req1_y(req1_y),
        .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y), .alu_z(alu_z),
        .rsp0_valid(rsp0_valid), .rsp0_z(rsp0_z), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_z(rsp1_z), .rsp1_err(rsp1_err),
        .busy(busy)
    );

    // Stand-in ALU: a pure function of its (registered) inputs.
    function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] x,
                                           input logic [15:0] y);
        logic [15:0] r;
        case (op)
            4'b0000: r = x + y;
            4'b0100: r = x & y;
            4'b0101: r = x | y;
            4'b0110: r = x ^ y;
            4'b0111: r = {15'd0, |x};
            4'b1000: r = x;
            4'b1001: r = x >> 1;
            default: r = (x * 16'd3) ^ {y[7:0], y[15:8]} ^ {op, 12'h5A5};
        endcase
        return r;
    endfunction

    assign alu_z = alu_fn(alu_op, alu_x, alu_y);

    function automatic int lat_of(input logic [3:0] op);
        if (op >= 4'd12) return 0;
        if (op inside {4'd1, 4'd2, 4'd3, 4'd10, 4'd11}) return FL;
        return 1;
    endfunction

    int          n_cmp = 0;
    int          n_bad = 0;
    int          t = 0;
    bit          m_known = 1'b0;
    int          m_free = 0;
    int          m_rsp_cyc = -1;
    bit          m_rsp_port;
    logic [15:0] m_rsp_z;
    bit          m_rsp_err;
    bit          m_rr;
    logic [3:0]  m_op;
    logic [15:0] m_x, m_y;
    bit          rst_at_edge;
    int          dut_grants[$];
    int          rsp_seen;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    // Compare this cycle's outputs against the model, then apply any grant.
    task automatic sample();
        bit idle, g0, g1, r0, r1;
        int L;
        logic [3:0] op;
        logic [15:0] x, y;
        @(negedge clk);
        rst_at_edge = !reset_n;
        if (req0_ready) dut_grants.push_back(0);
        if (req1_ready) dut_grants.push_back(1);
        if (rsp0_valid || rsp1_valid) rsp_seen++;
        if (m_known) begin
            idle = (t >= m_free);
            g0 = reset_n && idle && req0_valid && (!req1_valid || !m_rr);
            g1 = reset_n && idle && req1_valid && (!req0_valid || m_rr);
            r0 = (t == m_rsp_cyc) && !m_rsp_port;
            r1 = (t == m_rsp_cyc) &&  m_rsp_port;
            chk("ready0", 16'(req0_ready), 16'(g0));
            chk("ready1", 16'(req1_ready), 16'(g1));
            chk("busy", 16'(busy), 16'(!idle));
            chk("rsp0_valid", 16'(rsp0_valid), 16'(r0));
            chk("rsp1_valid", 16'(rsp1_valid), 16'(r1));
            chk("rsp0_z", rsp0_z, r0 ? m_rsp_z : 16'h0000);
            chk("rsp1_z", rsp1_z, r1 ? m_rsp_z : 16'h0000);
            chk("rsp0_err", 16'(rsp0_err), 16'(r0 && m_rsp_err));
            chk("rsp1_err", 16'(rsp1_err), 16'(r1 && m_rsp_err));
            chk("alu_op", 16'(alu_op), 16'(m_op));
            chk("alu_x", alu_x, m_x);
            chk("alu_y", alu_y, m_y);
            if (g0 || g1) begin
                op = g1 ? req1_op : req0_op;
                x  = g1 ? req1_x  : req0_x;
                y  = g1 ? req1_y  : req0_y;
                L  = lat_of(op);
                m_rsp_cyc  = t + L + 1;
                m_free     = t + L + 2;
                m_rsp_port = g1;
                m_rsp_err  = (L == 0);
                m_rsp_z    = (L == 0) ? 16'h0000 : alu_fn(op, x, y);
                m_rr       = !g1;
                if (L != 0) begin
                    m_op = op;
                    m_x  = x;
                    m_y  = y;
                end
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        t++;
        if (rst_at_edge) begin
            m_known   = 1'b1;
            m_free    = t;
            m_rsp_cyc = -1;
            m_rr      = 1'b0;
            m_op      = 4'h8;
            m_x       = 16'h0000;
            m_y       = 16'h0000;
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            advance();
        end
    endtask

    initial begin
        // Reset with both requesters valid.
        reset_n = 1'b0;
        req0_valid = 1'b1; req0_op = 4'h0; req0_x = 16'h0011; req0_y = 16'h0022;
        req1_valid = 1'b1; req1_op = 4'h0; req1_x = 16'h0100; req1_y = 16'h0200;
        cyc(1);
        sample();
        chk("rst_alu_op", 16'(alu_op), 16'h0008);
        chk("rst_ready0", 16'(req0_ready), 16'h0000);
        advance();

        // Contention from reset: grants must alternate 0,1,0.
        reset_n = 1'b1;
        dut_grants.delete();
        sample();
        chk("first_ready0", 16'(req0_ready), 16'h0001);
        advance();
        cyc(8);
        chk("grant_cnt", 16'(dut_grants.size()), 16'd3);
        if (dut_grants.size() == 3) begin
            chk("grant_0", 16'(dut_grants[0]), 16'd0);
            chk("grant_1", 16'(dut_grants[1]), 16'd1);
            chk("grant_2", 16'(dut_grants[2]), 16'd0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        cyc(2);

        // Int add 3+4 from requester 0; operands scrambled after handshake.
        req0_valid = 1'b1; req0_op = 4'h0; req0_x = 16'h0003; req0_y = 16'h0004;
        cyc(1);
        req0_valid = 1'b0; req0_x = 16'hDEAD; req0_y = 16'hBEEF;
        sample(); chk("int_alu_x", alu_x, 16'h0003); advance();
        sample();
        chk("int_rsp_v", 16'(rsp0_valid), 16'h0001);
        chk("int_rsp_z", rsp0_z, 16'h0007);
        chk("int_rsp_err", 16'(rsp0_err), 16'h0000);
        advance();
        sample(); chk("int_rsp_once", 16'(rsp0_valid), 16'h0000); advance();

        // Float mulf from requester 1: inputs held for FL cycles.
        req1_valid = 1'b1; req1_op = 4'h3; req1_x = 16'h3FC0; req1_y = 16'h4000;
        cyc(1);
        req1_valid = 1'b0; req1_x = 16'h1234;
        for (int i = 0; i < FL; i++) begin
            sample();
            chk("flt_op", 16'(alu_op), 16'h0003);
            chk("flt_x", alu_x, 16'h3FC0);
            chk("flt_y", alu_y, 16'h4000);
            chk("flt_no_rsp", 16'(rsp1_valid), 16'h0000);
            advance();
        end
        sample();
        chk("flt_rsp_v", 16'(rsp1_valid), 16'h0001);
        chk("flt_rsp_z", rsp1_z, alu_fn(4'h3, 16'h3FC0, 16'h4000));
        advance();
        cyc(1);

        // Illegal op: immediate error response, ALU inputs untouched.
        req0_valid = 1'b1; req0_op = 4'hD; req0_x = 16'h7777; req0_y = 16'h8888;
        cyc(1);
        req0_valid = 1'b0;
        sample();
        chk("ill_rsp_v", 16'(rsp0_valid), 16'h0001);
        chk("ill_rsp_err", 16'(rsp0_err), 16'h0001);
        chk("ill_rsp_z", rsp0_z, 16'h0000);
        chk("ill_alu_op", 16'(alu_op), 16'h0003);
        advance();
        cyc(1);

        // Abort: reset mid float op owned by requester 1.
        req1_valid = 1'b1; req1_op = 4'h2; req1_x = 16'h0042; req1_y = 16'h0043;
        cyc(1);
        req1_valid = 1'b0;
        rsp_seen = 0;
        cyc(1);
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        sample(); chk("abort_idle", 16'(busy), 16'h0000); advance();
        cyc(4);
        chk("abort_no_rsp", 16'(rsp_seen), 16'd0);
        req0_valid = 1'b1; req1_valid = 1'b1; req0_op = 4'h4; req1_op = 4'h5;
        sample(); chk("abort_next_gnt0", 16'(req0_ready), 16'h0001); advance();
        req0_valid = 1'b0; req1_valid = 1'b0;
        cyc(4);

        // Randomized traffic, occasional resets and input churn.
        for (int i = 0; i < 600; i++) begin
            reset_n    = ($urandom_range(0, 63) != 0);
            req0_valid = $urandom_range(0, 2) != 0;
            req1_valid = $urandom_range(0, 2) != 0;
            req0_op    = 4'($urandom_range(0, 15));
            req1_op    = 4'($urandom_range(0, 15));
            req0_x     = 16'($urandom);
            req0_y     = 16'($urandom);
            req1_x     = 16'($urandom);
            req1_y     = 16'($urandom);
            cyc(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
